// File: rtl/sda_rx_pkg.sv
// sda_rx_pkg
//   Shared types and defaults for the scl/sda serial receiver.
//   - rx_state_e       : receiver FSM states
//   - DEF_WIDTH        : default data bits per frame
//   - DEF_SYNC_STAGES  : default synchroniser depth on scl/sda
package sda_rx_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_STOP = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sda_to_par_rx_sync_edge.sv
// sync_edge
//   Multi-flop synchroniser for one asynchronous input, plus a one-cycle
//   delayed copy of the synchronised level for edge detection.
//   The chain resets to 1 so that an idle-high bus produces no edges out of reset.
// Ports
//   sclk   in   system clock
//   rst    in   synchronous active-high reset
//   d      in   asynchronous input
//   level  out  synchronised level (last chain stage)
//   prev   out  level as seen one sclk cycle earlier
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic sclk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic prev
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge sclk) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/sda_to_par_rx.sv
// sda_to_par_rx
//   Receiver for the scl/sda serial link: detects start, WIDTH data bits
//   (MSB first) and stop, then presents the word in parallel and as a
//   registered one-hot decode. scl/sda are oversampled on sclk.
// Ports
//   sclk       in   system clock
//   rst        in   synchronous active-high reset
//   scl        in   serial clock from link
//   sda        in   serial data from link
//   data       out  last good word, held until the next good frame
//   valid      out  1-cycle pulse when data/outhigh update
//   outhigh    out  one-hot of data, 2**WIDTH wide
//   busy       out  high while a frame is in progress
//   frame_err  out  1-cycle pulse on a malformed frame
module sda_to_par_rx
    import sda_rx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic [WIDTH-1:0]      data,
    output logic                  valid,
    output logic [(2**WIDTH)-1:0] outhigh,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = 2 ** WIDTH;

    logic scl_s, scl_p, sda_s, sda_p;

    sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .sclk  (sclk),
        .rst   (rst),
        .d     (scl),
        .level (scl_s),
        .prev  (scl_p)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .sclk  (sclk),
        .rst   (rst),
        .d     (sda),
        .level (sda_s),
        .prev  (sda_p)
    );

    // START/STOP need scl high on both samples, RISE needs scl low on the
    // previous one, so the three are mutually exclusive and a simultaneous
    // scl/sda change decodes as RISE only.
    logic ev_start, ev_stop, ev_rise;
    assign ev_start = scl_s & scl_p &  sda_p & ~sda_s;
    assign ev_stop  = scl_s & scl_p & ~sda_p &  sda_s;
    assign ev_rise  = scl_s & ~scl_p;

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_d;
    logic [OW-1:0]    outhigh_d;
    logic             valid_d, ferr_d;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            data      <= '0;
            outhigh   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            data      <= data_d;
            outhigh   <= outhigh_d;
            valid     <= valid_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        data_d    = data;
        outhigh_d = outhigh;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ev_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (ev_rise) begin
                    shreg_d = {shreg_q[WIDTH-2:0], sda_s};
                    // Last bit: park cnt at 0 so it never passes WIDTH-1.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = WAIT_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (ev_start) begin
                    // Repeated start restarts the word without error.
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (ev_stop) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_STOP: begin
                // The trailing low bit's scl rise lands here and is ignored.
                if (ev_stop) begin
                    data_d            = shreg_q;
                    outhigh_d         = '0;
                    outhigh_d[shreg_q] = 1'b1;
                    valid_d           = 1'b1;
                    state_d           = IDLE;
                end else if (ev_start) begin
                    ferr_d  = 1'b1;
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
